// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: grants up to WB_PORTS of NUM_REQ result producers per
// cycle and forwards the granted results on registered writeback slots one cycle later.
module wb_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WB_PORTS   = 2,
  parameter int DATA_WIDTH = 32,
  parameter int PREG_W     = 6
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 flush,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ-1:0][PREG_W-1:0]       req_phys_rd,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic [WB_PORTS-1:0]                  wb_valid,
  output logic [WB_PORTS-1:0][PREG_W-1:0]      wb_phys_rd,
  output logic [WB_PORTS-1:0][DATA_WIDTH-1:0]  wb_data,
  output logic [31:0]                          grant_cnt
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int SLOT_W = (WB_PORTS > 1) ? $clog2(WB_PORTS) : 1;

  logic [IDX_W-1:0]                    rr_ptr_r;
  logic [IDX_W-1:0]                    rr_next_s;
  logic [NUM_REQ-1:0]                  grant_s;
  logic [NUM_REQ-1:0][SLOT_W-1:0]      slot_of_s;
  logic                                take_s;
  logic                                sel_s;
  int                                  gcount_s;
  int                                  last_s;

  logic [WB_PORTS-1:0]                 wb_valid_r;
  logic [WB_PORTS-1:0][PREG_W-1:0]     wb_phys_rd_r;
  logic [WB_PORTS-1:0][DATA_WIDTH-1:0] wb_data_r;
  logic [31:0]                         grant_cnt_r;
  logic [WB_PORTS-1:0]                 wb_valid_nxt_s;
  logic [WB_PORTS-1:0][PREG_W-1:0]     wb_phys_rd_nxt_s;
  logic [WB_PORTS-1:0][DATA_WIDTH-1:0] wb_data_nxt_s;

  // Scan requesters from rr_ptr in wrap order; the first WB_PORTS valid ones take slots 0,1,...
  always_comb begin
    grant_s   = '0;
    slot_of_s = '0;
    gcount_s  = 0;
    last_s    = 0;
    take_s    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        take_s       = (((int'(rr_ptr_r) + k) % NUM_REQ) == i) && !flush && req_valid[i]
                       && (gcount_s < WB_PORTS);
        grant_s[i]   = grant_s[i] | take_s;
        slot_of_s[i] = take_s ? SLOT_W'(gcount_s) : slot_of_s[i];
        last_s       = take_s ? i : last_s;
        gcount_s     = gcount_s + (take_s ? 1 : 0);
      end
    end
  end

  // Pointer moves just past the last granted requester; no grant leaves it in place.
  always_comb begin
    if (gcount_s > 0) begin
      rr_next_s = IDX_W'((last_s + 1) % NUM_REQ);
    end else begin
      rr_next_s = rr_ptr_r;
    end
  end

  // Route each granted requester onto its slot; idle slots keep their previous payload.
  always_comb begin
    wb_valid_nxt_s   = '0;
    wb_phys_rd_nxt_s = wb_phys_rd_r;
    wb_data_nxt_s    = wb_data_r;
    sel_s            = 1'b0;
    for (int k = 0; k < WB_PORTS; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        sel_s               = grant_s[i] && (slot_of_s[i] == SLOT_W'(k));
        wb_valid_nxt_s[k]   = wb_valid_nxt_s[k] | sel_s;
        wb_phys_rd_nxt_s[k] = sel_s ? req_phys_rd[i] : wb_phys_rd_nxt_s[k];
        wb_data_nxt_s[k]    = sel_s ? req_data[i] : wb_data_nxt_s[k];
      end
    end
  end

  // Arbiter state and registered writeback outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r     <= '0;
      grant_cnt_r  <= 32'd0;
      wb_valid_r   <= '0;
      wb_phys_rd_r <= '0;
      wb_data_r    <= '0;
    end else begin
      rr_ptr_r     <= rr_next_s;
      grant_cnt_r  <= grant_cnt_r + 32'(gcount_s);
      wb_valid_r   <= wb_valid_nxt_s;
      wb_phys_rd_r <= wb_phys_rd_nxt_s;
      wb_data_r    <= wb_data_nxt_s;
    end
  end

  assign req_ready  = grant_s;
  assign wb_valid   = wb_valid_r;
  assign wb_phys_rd = wb_phys_rd_r;
  assign wb_data    = wb_data_r;
  assign grant_cnt  = grant_cnt_r;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed-vector bench for wb_arbiter; the driver pushes expected writebacks into a queue
// and an independent monitor pops and compares whenever wb_valid is asserted.
module tb_wb_arbiter;

  localparam int NV = 14;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic [3:0]       req_valid;
  logic [3:0][5:0]  req_phys_rd;
  logic [3:0][31:0] req_data;
  logic [3:0]       req_ready;
  logic [1:0]       wb_valid;
  logic [1:0][5:0]  wb_phys_rd;
  logic [1:0][31:0] wb_data;
  logic [31:0]      grant_cnt;

  typedef struct packed {
    logic [1:0]       v;
    logic [1:0][5:0]  rd;
    logic [1:0][31:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Hand-computed vectors, starting from rr_ptr=0 after reset.
  logic [3:0] vec_valid [NV] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h4, 4'h9, 4'hF, 4'hF, 4'h0, 4'h1, 4'hA, 4'h8, 4'h6, 4'h7};
  logic       vec_flush [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [3:0] vec_ready [NV] = '{4'h3, 4'hC, 4'h3, 4'hC, 4'h4, 4'h9, 4'h0, 4'h6, 4'h0, 4'h1, 4'hA, 4'h8, 4'h6, 4'h3};
  int         vec_s0    [NV] = '{0, 2, 0, 2, 2, 3, -1, 1, -1, 0, 1, 3, 1, 0};
  int         vec_s1    [NV] = '{1, 3, 1, 3, -1, 0, -1, 2, -1, -1, 3, -1, 2, 1};

  wb_arbiter #(.NUM_REQ(4), .WB_PORTS(2), .DATA_WIDTH(32), .PREG_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_phys_rd (req_phys_rd),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .wb_valid    (wb_valid),
    .wb_phys_rd  (wb_phys_rd),
    .wb_data     (wb_data),
    .grant_cnt   (grant_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] rd_of(int v, int i);
    return 6'(v * 4 + i);
  endfunction

  function automatic logic [31:0] data_of(int v, int i);
    return 32'hC0DE_0000 + 32'(v * 16 + i);
  endfunction

  task automatic chk(string name, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Monitor: every asserted writeback must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n === 1'b1 && wb_valid !== 2'b00) begin
        if (exp_q.size() == 0) begin
          chk("wb_unexpected", 64'(wb_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("wb_valid", 64'(wb_valid), 64'(e.v));
          chk("wb_phys_rd", 64'(wb_phys_rd), 64'(e.rd));
          chk("wb_data", 64'(wb_data), 64'(e.d));
        end
      end
    end
  end

  // Driver: applies vectors at negedge, checks grants, queues expected writebacks.
  initial begin
    logic [1:0][5:0]  last_rd;
    logic [1:0][31:0] last_d;
    logic [31:0]      cnt_exp;
    exp_t             e;
    last_rd     = '0;
    last_d      = '0;
    cnt_exp     = 32'd0;
    rst_n       = 1'b0;
    flush       = 1'b0;
    req_valid   = 4'h0;
    req_phys_rd = '0;
    req_data    = '0;
    #2;
    chk("reset_wb_valid", 64'(wb_valid), 64'd0);
    chk("reset_grant_cnt", 64'(grant_cnt), 64'd0);
    chk("reset_wb_data", 64'(wb_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < NV; v++) begin
      @(negedge clk);
      chk("grant_cnt", 64'(grant_cnt), 64'(cnt_exp));
      req_valid = vec_valid[v];
      flush     = vec_flush[v];
      for (int i = 0; i < 4; i++) begin
        req_phys_rd[i] = rd_of(v, i);
        req_data[i]    = data_of(v, i);
      end
      #1;
      chk("req_ready", 64'(req_ready), 64'(vec_ready[v]));
      if (vec_s0[v] >= 0) begin
        e.v = 2'b00;
        if (vec_s0[v] >= 0) begin
          e.v[0]     = 1'b1;
          last_rd[0] = rd_of(v, vec_s0[v]);
          last_d[0]  = data_of(v, vec_s0[v]);
        end
        if (vec_s1[v] >= 0) begin
          e.v[1]     = 1'b1;
          last_rd[1] = rd_of(v, vec_s1[v]);
          last_d[1]  = data_of(v, vec_s1[v]);
        end
        e.rd = last_rd;
        e.d  = last_d;
        exp_q.push_back(e);
      end
      cnt_exp = cnt_exp + 32'(vec_ready[v][0]) + 32'(vec_ready[v][1])
                        + 32'(vec_ready[v][2]) + 32'(vec_ready[v][3]);
    end

    @(negedge clk);
    req_valid = 4'h0;
    flush     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("final_grant_cnt", 64'(grant_cnt), 64'd21);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset asserted mid-cycle while every requester is valid.
    req_valid = 4'hF;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_wb_valid", 64'(wb_valid), 64'd0);
    chk("midreset_grant_cnt", 64'(grant_cnt), 64'd0);
    @(negedge clk);
    chk("held_reset_wb_valid", 64'(wb_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
